// File: rtl/sgpio_pkg.sv
// Shared SGPIO definitions: per-drive field layout, vendor field width and FSM states.
package sgpio_pkg;

  localparam int SGPIO_BITS_PER_DRV = 3;
  localparam int SGPIO_ACT          = 0;
  localparam int SGPIO_LOC          = 1;
  localparam int SGPIO_FAIL         = 2;
  localparam int SGPIO_VENDOR_BITS  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sgpio_state_e;

endpackage

// File: rtl/sgpio_clkgen.sv
// SCLK generator: divider plus phase toggle, with single-cycle strobes on the
// SYSCLK edges that take SCLK high (rise_stb) and low (fall_stb).
module sgpio_clkgen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] TC = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          phase_q, phase_d;
  logic          tc;

  assign tc       = run && (div_q == TC);
  assign rise_stb = tc && !phase_q;
  assign fall_stb = tc && phase_q;
  assign sclk     = phase_q;

  // Held at zero while stopped so every frame starts with a full low phase.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!run) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (tc) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/sgpio_initiator.sv
// SGPIO initiator: serialises ACT/LOC/FAIL per drive onto SDOUT with SLOAD
// framing and vendor bits, and captures the returning SDIN frame.
module sgpio_initiator
  import sgpio_pkg::*;
#(
  parameter int NUM_DRV = 36,
  parameter int CLK_DIV = 250
) (
  input  logic                                 SYSCLK,
  input  logic                                 RESET,
  input  logic                                 ENABLE,
  input  logic [NUM_DRV-1:0]                   ACT,
  input  logic [NUM_DRV-1:0]                   LOC,
  input  logic [NUM_DRV-1:0]                   FAIL,
  input  logic [SGPIO_VENDOR_BITS-1:0]         VENDOR,
  input  logic                                 SDIN,
  output logic                                 SCLK,
  output logic                                 SLOAD,
  output logic                                 SDOUT,
  output logic [SGPIO_BITS_PER_DRV*NUM_DRV-1:0] SDIN_REG,
  output logic                                 FRAME_DONE,
  output logic                                 BUSY
);

  localparam int FB = SGPIO_BITS_PER_DRV * NUM_DRV;
  localparam int CW = $clog2(FB);
  localparam int VW = $clog2(SGPIO_VENDOR_BITS);
  localparam logic [CW-1:0] LAST = CW'(FB - 1);

  sgpio_state_e                 state_q, state_d;
  logic [CW-1:0]                bit_q, bit_d, bit_nx;
  logic [FB-1:0]                frame_q, frame_d, live_frame;
  logic [SGPIO_VENDOR_BITS-1:0] vendor_q, vendor_d;
  logic [FB-1:0]                rx_q, rx_d;
  logic [FB-1:0]                sdin_reg_q, sdin_reg_d;
  logic                         sload_q, sload_d;
  logic                         sdout_q, sdout_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         rise_stb, fall_stb, sclk;

  // Flatten the per-drive inputs into frame bit order.
  for (genvar gi = 0; gi < NUM_DRV; gi++) begin : g_frame
    assign live_frame[SGPIO_BITS_PER_DRV*gi + SGPIO_ACT]  = ACT[gi];
    assign live_frame[SGPIO_BITS_PER_DRV*gi + SGPIO_LOC]  = LOC[gi];
    assign live_frame[SGPIO_BITS_PER_DRV*gi + SGPIO_FAIL] = FAIL[gi];
  end

  sgpio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (SYSCLK),
    .rst      (RESET),
    .run      (state_q == ST_SHIFT),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  function automatic logic sload_bit(input logic [CW-1:0] b,
                                     input logic [SGPIO_VENDOR_BITS-1:0] v);
    logic [CW-1:0] vi;
    vi = b - 1'b1;
    if (b == '0)
      return 1'b1;
    else if (b <= CW'(SGPIO_VENDOR_BITS))
      return v[vi[VW-1:0]];
    else
      return 1'b0;
  endfunction

  assign bit_nx = bit_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    vendor_d   = vendor_q;
    rx_d       = rx_q;
    sdin_reg_d = sdin_reg_q;
    sload_d    = sload_q;
    sdout_d    = sdout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sload_d = 1'b0;
        sdout_d = 1'b0;
        busy_d  = 1'b0;
        if (ENABLE) begin
          state_d  = ST_SHIFT;
          frame_d  = live_frame;
          vendor_d = VENDOR;
          bit_d    = '0;
          busy_d   = 1'b1;
          sload_d  = 1'b1;
          sdout_d  = live_frame[0];
        end
      end
      ST_SHIFT: begin
        if (rise_stb)
          rx_d[bit_q] = SDIN;
        if (fall_stb) begin
          if (bit_q == LAST) begin
            done_d     = 1'b1;
            sdin_reg_d = rx_q;
            bit_d      = '0;
            // A new snapshot on the boundary edge keeps frames gapless.
            if (ENABLE) begin
              frame_d  = live_frame;
              vendor_d = VENDOR;
              sload_d  = 1'b1;
              sdout_d  = live_frame[0];
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              sload_d = 1'b0;
              sdout_d = 1'b0;
            end
          end else begin
            bit_d   = bit_nx;
            sdout_d = frame_q[bit_nx];
            sload_d = sload_bit(bit_nx, vendor_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      frame_q    <= '0;
      vendor_q   <= '0;
      rx_q       <= '0;
      sdin_reg_q <= '0;
      sload_q    <= 1'b0;
      sdout_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      vendor_q   <= vendor_d;
      rx_q       <= rx_d;
      sdin_reg_q <= sdin_reg_d;
      sload_q    <= sload_d;
      sdout_q    <= sdout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign SCLK       = sclk;
  assign SLOAD      = sload_q;
  assign SDOUT      = sdout_q;
  assign SDIN_REG   = sdin_reg_q;
  assign FRAME_DONE = done_q;
  assign BUSY       = busy_q;

endmodule
